// File: rtl/history_dump_ctrl.sv
// history_dump_ctrl: streams a range of history-BRAM words to a ready/valid
// consumer while sharing the BRAM with the IREQ generator's write traffic.
// Reads and writes never share a cycle. A write that would collide with a read
// is parked in a one-entry hold buffer and retired on the next cycle.
module history_dump_ctrl #(
  parameter int TCQ = 100
) (
  input  logic        lnk_clk,
  input  logic        lnk_reset,
  input  logic        dump_start,
  input  logic [8:0]  dump_base,
  input  logic [9:0]  dump_count,
  output logic        dump_busy,
  output logic        dump_done,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [35:0] dump_data,
  output logic [8:0]  dump_addr,
  input  logic        g_wr_en,
  input  logic [8:0]  g_wr_addr,
  input  logic [35:0] g_wr_data,
  output logic        g_wr_stall,
  output logic        hist_rd_en,
  output logic [8:0]  hist_rd_addr,
  output logic        g_hist_wea,
  output logic [8:0]  g_hist_addra,
  output logic [35:0] g_hist_dia,
  input  logic [35:0] hist_dout
);

  // TCQ only models clock-to-out in behavioural sims; the RTL has no delays.
  logic unused_tcq;
  assign unused_tcq = |TCQ;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [9:0]  remain_q, remain_d;
  logic        zdone_q, zdone_d;
  // two-entry output FIFO
  logic [35:0] fdata_q [2];
  logic [35:0] fdata_d [2];
  logic [8:0]  faddr_q [2];
  logic [8:0]  faddr_d [2];
  logic        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]  cnt_q, cnt_d;
  // read in flight (BRAM latency is one cycle, so at most one)
  logic        infl_q, infl_d;
  logic [8:0]  infl_addr_q, infl_addr_d;
  // generator write hold buffer
  logic        hold_q, hold_d;
  logic [8:0]  hold_addr_q, hold_addr_d;
  logic [35:0] hold_data_q, hold_data_d;

  logic        rd, pop, drain_done;
  logic [1:0]  eff_occ;

  // Read issue and write-slot arbitration; all outputs forced to 0 in reset.
  always_comb begin
    pop        = (cnt_q != 2'd0) && dump_ready && !lnk_reset;
    // Occupancy counts the entry leaving this cycle as already gone, so a
    // ready consumer sees one word per cycle; the sum still never exceeds 2.
    eff_occ    = cnt_q - {1'b0, pop} + {1'b0, infl_q};
    rd         = !lnk_reset && (state_q == RUN) && (remain_q != 10'd0) &&
                 !hold_q && (eff_occ < 2'd2);
    drain_done = (state_q == DRAIN) && !infl_q && (cnt_q == 2'd0);

    hist_rd_en   = rd;
    hist_rd_addr = rd ? addr_q : 9'd0;
    dump_busy    = !lnk_reset && (state_q != IDLE);
    dump_done    = !lnk_reset && (zdone_q || drain_done);
    dump_valid   = !lnk_reset && (cnt_q != 2'd0);
    dump_data    = lnk_reset ? 36'd0 : fdata_q[rptr_q];
    dump_addr    = lnk_reset ? 9'd0  : faddr_q[rptr_q];
    g_wr_stall   = !lnk_reset && hold_q;

    g_hist_wea   = 1'b0;
    g_hist_addra = 9'd0;
    g_hist_dia   = 36'd0;
    hold_d       = hold_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (!lnk_reset) begin
      if (hold_q) begin
        g_hist_wea   = 1'b1;
        g_hist_addra = hold_addr_q;
        g_hist_dia   = hold_data_q;
        hold_d       = 1'b0;
      end else if (g_wr_en) begin
        if (rd) begin
          hold_d      = 1'b1;
          hold_addr_d = g_wr_addr;
          hold_data_d = g_wr_data;
        end else begin
          g_hist_wea   = 1'b1;
          g_hist_addra = g_wr_addr;
          g_hist_dia   = g_wr_data;
        end
      end
    end
  end

  // Dump FSM: address/remain bookkeeping and state transitions.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    zdone_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          if (dump_count != 10'd0) begin
            addr_d   = dump_base;
            remain_d = dump_count;
            state_d  = RUN;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd) begin
          addr_d   = addr_q + 9'd1;
          remain_d = remain_q - 10'd1;
        end
        if (remain_d == 10'd0) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO: capture BRAM data one cycle after its read, pop on handshake.
  always_comb begin
    fdata_d     = fdata_q;
    faddr_d     = faddr_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    infl_d      = rd;
    infl_addr_d = addr_q;
    if (infl_q) begin
      fdata_d[wptr_q] = hist_dout;
      faddr_d[wptr_q] = infl_addr_q;
      wptr_d          = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
  end

  // State registers with synchronous reset; a reset drops any read in flight.
  always_ff @(posedge lnk_clk) begin
    if (lnk_reset) begin
      state_q     <= IDLE;
      addr_q      <= 9'd0;
      remain_q    <= 10'd0;
      zdone_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fdata_q[i] <= 36'd0;
        faddr_q[i] <= 9'd0;
      end
      rptr_q      <= 1'b0;
      wptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      infl_q      <= 1'b0;
      infl_addr_q <= 9'd0;
      hold_q      <= 1'b0;
      hold_addr_q <= 9'd0;
      hold_data_q <= 36'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      zdone_q     <= zdone_d;
      fdata_q     <= fdata_d;
      faddr_q     <= faddr_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_history_dump_ctrl.sv
// Bench for history_dump_ctrl: BRAM model preloaded with addr+0x100, a
// table of dump scenarios, and hand sequences for write sharing and reset.
module tb_history_dump_ctrl;

  logic        clk = 1'b0;
  logic        lnk_reset, dump_start, dump_ready;
  logic [8:0]  dump_base;
  logic [9:0]  dump_count;
  logic        dump_busy, dump_done, dump_valid;
  logic [35:0] dump_data;
  logic [8:0]  dump_addr;
  logic        g_wr_en;
  logic [8:0]  g_wr_addr;
  logic [35:0] g_wr_data;
  logic        g_wr_stall, hist_rd_en, g_hist_wea;
  logic [8:0]  hist_rd_addr, g_hist_addra;
  logic [35:0] g_hist_dia, hist_dout;

  history_dump_ctrl #(.TCQ(100)) dut (
    .lnk_clk(clk), .lnk_reset(lnk_reset),
    .dump_start(dump_start), .dump_base(dump_base), .dump_count(dump_count),
    .dump_busy(dump_busy), .dump_done(dump_done), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .g_wr_en(g_wr_en), .g_wr_addr(g_wr_addr), .g_wr_data(g_wr_data),
    .g_wr_stall(g_wr_stall), .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
    .g_hist_wea(g_hist_wea), .g_hist_addra(g_hist_addra), .g_hist_dia(g_hist_dia),
    .hist_dout(hist_dout)
  );

  always #5 clk = ~clk;

  wire [104:0] all_outs = {dump_busy, dump_done, dump_valid, dump_data, dump_addr,
                           g_wr_stall, hist_rd_en, hist_rd_addr, g_hist_wea,
                           g_hist_addra, g_hist_dia};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // BRAM model: registered read, port-A write; preloaded on the first edge.
  logic [35:0] mem [512];
  bit pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int k = 0; k < 512; k++) mem[k] <= 36'(k) + 36'h100;
      pre_done <= 1'b1;
    end else if (g_hist_wea) mem[g_hist_addra] <= g_hist_dia;
    if (hist_rd_en) hist_dout <= mem[hist_rd_addr];
  end

  // Monitor: logs words, done pulses, reads, writes, and protocol violations.
  logic [8:0]  got_a [$];
  logic [35:0] got_d [$];
  int          got_c [$];
  int          done_c [$];
  logic [44:0] exp_w [$];
  logic [44:0] got_w [$];
  int rd_n = 0, pop_n = 0, out_base = 0, out_max = 0;
  int stab_bad = 0, coll_bad = 0, z_bad = 0, gap_bad = 0, last_rd = -1;
  bit gap_en = 1'b0;
  bit pv = 1'b0;
  logic [8:0]  pa;
  logic [35:0] pd;
  always @(negedge clk) begin
    if (dump_valid && dump_ready) begin
      got_a.push_back(dump_addr); got_d.push_back(dump_data); got_c.push_back(cyc);
      pop_n++;
    end
    if (dump_done) done_c.push_back(cyc);
    if (hist_rd_en) rd_n++;
    if (lnk_reset) out_base = rd_n - pop_n;
    if (rd_n - pop_n - out_base > out_max) out_max = rd_n - pop_n - out_base;
    if (hist_rd_en && g_hist_wea) coll_bad++;
    if (!g_hist_wea && (g_hist_addra != 9'd0 || g_hist_dia != 36'd0)) z_bad++;
    if (pv && !lnk_reset && (!dump_valid || dump_addr != pa || dump_data != pd)) stab_bad++;
    pv = dump_valid && !dump_ready; pa = dump_addr; pd = dump_data;
    if (!gap_en) last_rd = -1;
    else if (hist_rd_en) begin
      if (last_rd >= 0 && cyc - last_rd > 2) gap_bad++;
      last_rd = cyc;
    end
    if (!lnk_reset && g_wr_en && !g_wr_stall) exp_w.push_back({g_wr_addr, g_wr_data});
    if (g_hist_wea) got_w.push_back({g_hist_addra, g_hist_dia});
  end

  // Generator model: 0 idle, 1 writes every cycle obeying stall, 2 ignores stall.
  int wr_mode = 2;
  int wr_k = 0;
  initial begin
    g_wr_en = 1'b0; g_wr_addr = 9'd0; g_wr_data = 36'd0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        1:       g_wr_en = !g_wr_stall;
        2:       g_wr_en = 1'b1;
        default: g_wr_en = 1'b0;
      endcase
      g_wr_addr = 9'(300 + (wr_k % 64));
      g_wr_data = {4'hA, 32'($urandom)};
      wr_k++;
    end
  end

  typedef struct {
    logic [8:0] base;
    logic [9:0] cnt;
    bit         consec;
    int         stall_off;
    int         restart_off;
    bit         rel;
    int         exp_n;
    logic [8:0] exp_last;
  } vec_t;

  task automatic run_dump(input vec_t v);
    int t0, n, i0, d0, r0, li;
    logic [8:0] ea;
    i0 = got_a.size(); d0 = done_c.size(); r0 = rd_n;
    @(posedge clk); #1;
    dump_base = v.base; dump_count = v.cnt; dump_start = 1'b1;
    if (v.rel) lnk_reset = 1'b0;
    @(posedge clk); #1;
    dump_start = 1'b0; dump_base = 9'h1AA; dump_count = 10'd7;
    t0 = cyc; n = 0;
    @(negedge clk);
    chk("busy_after_start", dump_busy, v.cnt != 10'd0);
    while (done_c.size() == d0 && n < 3000) begin
      @(posedge clk); #1; n++;
      dump_start = (n == v.restart_off);
      dump_ready = !(v.stall_off >= 0 && n >= v.stall_off && n < v.stall_off + 10);
    end
    dump_start = 1'b0; dump_ready = 1'b1;
    chk("done_in_time", n < 3000, 1);
    @(negedge clk);
    chk("busy_after_done", dump_busy, 0);
    repeat (3) @(negedge clk);
    chk("done_once", done_c.size() - d0, 1);
    chk("read_count", rd_n - r0, v.exp_n);
    chk("word_count", got_a.size() - i0, v.exp_n);
    for (int i = 0; i < v.exp_n && i0 + i < got_a.size(); i++) begin
      ea = v.base + 9'(i);
      chk("word_addr", got_a[i0 + i], ea);
      chk("word_data", got_d[i0 + i], {27'd0, ea} + 36'h100);
    end
    if (v.exp_n > 0 && got_a.size() - i0 == v.exp_n && done_c.size() > d0) begin
      li = got_a.size() - 1;
      chk("last_addr", got_a[li], v.exp_last);
      chk("done_after_last", done_c[d0], got_c[li] + 1);
      if (v.consec) chk("consecutive", got_c[li] - got_c[i0], v.exp_n - 1);
    end else if (v.exp_n == 0 && done_c.size() > d0) begin
      chk("zero_done_cycle", done_c[d0], t0);
    end
  endtask

  task automatic chk_writes(input int w0, input int g0, input string nm);
    int ne;
    ne = exp_w.size() - w0;
    chk({nm, "_count"}, got_w.size() - g0, ne);
    for (int i = 0; i < ne && g0 + i < got_w.size(); i++)
      chk({nm, "_order"}, got_w[g0 + i], exp_w[w0 + i]);
  endtask

  vec_t vt [7];
  vec_t vw;
  initial begin
    int w0, g0, i0, d0, n;
    vt[0] = '{9'd0,   10'd4,   1'b1, -1, -1, 1'b1, 4,   9'd3};
    vt[1] = '{9'd510, 10'd4,   1'b1, -1, -1, 1'b0, 4,   9'd1};
    vt[2] = '{9'd0,   10'd0,   1'b0, -1, -1, 1'b0, 0,   9'd0};
    vt[3] = '{9'd100, 10'd1,   1'b1, -1, -1, 1'b0, 1,   9'd100};
    vt[4] = '{9'd200, 10'd12,  1'b0,  3,  5, 1'b0, 12,  9'd211};
    vt[5] = '{9'd511, 10'd2,   1'b1, -1, -1, 1'b0, 2,   9'd0};
    vt[6] = '{9'd7,   10'd512, 1'b1, -1, -1, 1'b0, 512, 9'd6};

    lnk_reset = 1'b1; dump_start = 1'b0; dump_ready = 1'b1;
    dump_base = 9'd0; dump_count = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs, 0);
    @(posedge clk); #1; wr_mode = 0;
    repeat (2) @(posedge clk);

    // first vector releases reset in the same step as its start pulse
    for (int i = 0; i < 7; i++) run_dump(vt[i]);

    // generator writing every cycle during a 16-word dump
    w0 = exp_w.size(); g0 = got_w.size();
    @(posedge clk); #1; wr_mode = 1; gap_en = 1'b1;
    vw = '{9'd0, 10'd16, 1'b0, -1, -1, 1'b0, 16, 9'd15};
    run_dump(vw);
    gap_en = 1'b0; wr_mode = 0;
    repeat (3) @(posedge clk);
    chk_writes(w0, g0, "wr_obey");
    chk("read_gap", gap_bad, 0);

    // generator ignoring stall: stalled writes must be dropped
    w0 = exp_w.size(); g0 = got_w.size();
    @(posedge clk); #1; wr_mode = 2;
    vw = '{9'd5, 10'd6, 1'b0, -1, -1, 1'b0, 6, 9'd10};
    run_dump(vw);
    wr_mode = 0;
    repeat (3) @(posedge clk);
    chk_writes(w0, g0, "wr_blind");

    // reset three words into an 8-word dump
    i0 = got_a.size(); d0 = done_c.size();
    @(posedge clk); #1; dump_base = 9'd20; dump_count = 10'd8; dump_start = 1'b1;
    @(posedge clk); #1; dump_start = 1'b0; n = 0;
    while (got_a.size() - i0 < 3 && n < 200) begin @(posedge clk); n++; end
    #1; lnk_reset = 1'b1;
    chk("mid_reset_reached", n < 200, 1);
    @(negedge clk);
    chk("mid_reset_outputs", all_outs, 0);
    repeat (2) @(posedge clk);
    #1; lnk_reset = 1'b0;
    @(negedge clk);
    chk("no_capture_after_reset", dump_valid, 0);
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_c.size() - d0, 0);
    chk("words_before_reset", got_a.size() - i0, 3);
    for (int i = 0; i < 3 && i0 + i < got_a.size(); i++)
      chk("pre_reset_addr", got_a[i0 + i], 9'(20 + i));
    vw = '{9'd40, 10'd5, 1'b1, -1, -1, 1'b0, 5, 9'd44};
    run_dump(vw);

    chk("no_rd_wr_collision", coll_bad, 0);
    chk("porta_zero_when_idle", z_bad, 0);
    chk("data_stable_stalled", stab_bad, 0);
    chk("outstanding_le_2", out_max <= 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/history_dump_ctrl.md
HISTORY_DUMP_CTRL -- requirements
Module: history_dump_ctrl

Interface
REQ-001 SHALL have parameter: TCQ, 100, clock-to-out delay in ps applied to all registered assignments (simulation only).
REQ-002 SHALL have ports, clock and reset first:
- lnk_clk  in  1  link clock; all logic on its rising edge.
- lnk_reset  in  1  synchronous, active-high reset.
- dump_start  in  1  one-cycle pulse; begins a dump.
- dump_base  in  9  first history address of the dump, sampled with dump_start.
- dump_count  in  10  number of words to dump, 0..512, sampled with dump_start.
- dump_busy  out  1  high from the cycle after an accepted start until dump_done.
- dump_done  out  1  one-cycle pulse; dump complete.
- dump_valid  out  1  dump_data/dump_addr valid.
- dump_ready  in  1  downstream accepts the word when dump_valid & dump_ready.
- dump_data  out  36  history word read.
- dump_addr  out  9  address of the word in dump_data.
- g_wr_en  in  1  IREQ generator write request.
- g_wr_addr  in  9  generator write address.
- g_wr_data  in  36  generator write data.
- g_wr_stall  out  1  hold buffer full; generator SHALL NOT assert g_wr_en while high.
- hist_rd_en  out  1  BRAM read strobe.
- hist_rd_addr  out  9  BRAM read address.
- g_hist_wea  out  1  BRAM port-A write enable.
- g_hist_addra  out  9  BRAM port-A write address.
- g_hist_dia  out  36  BRAM port-A write data.
- hist_dout  in  36  BRAM read data, valid the cycle after hist_rd_en.

Function
REQ-003 SHALL implement states IDLE, RUN and DRAIN.
REQ-004 IDLE with dump_start: count != 0 -> load addr = dump_base and remain = dump_count, go to RUN; count == 0 -> pulse dump_done next cycle, stay IDLE.
REQ-005 dump_start SHALL be ignored outside IDLE.
REQ-006 RUN: a read SHALL issue (hist_rd_en=1, hist_rd_addr=addr) only when remain != 0, hold buffer empty, and (output FIFO occupancy + reads in flight) < 2.
REQ-007 Each issued read SHALL increment addr modulo 512 (511 -> 0) and decrement remain.
REQ-008 RUN -> DRAIN in the cycle after the read that makes remain 0.
REQ-009 DRAIN -> IDLE when no read is in flight and the output FIFO is empty; dump_done SHALL pulse in the same cycle as the transition.
REQ-010 The output FIFO SHALL hold 2 entries. Data SHALL be captured from hist_dout, together with its address, exactly 1 cycle after the read. Order SHALL be preserved. The FIFO SHALL never overflow.
REQ-011 dump_valid SHALL be high whenever the FIFO is non-empty, showing the head entry. dump_data and dump_addr SHALL remain stable while dump_valid & !dump_ready.
REQ-012 Write slots:
- Hold buffer full: drive g_hist_wea=1 with the hold contents, suppress the read, clear the hold.
- Hold buffer empty, g_wr_en, no read issued this cycle: pass through directly to the BRAM in the same cycle (combinational path).
- Hold buffer empty, g_wr_en, read issued this cycle: capture the write into the hold buffer.
REQ-013 g_wr_stall SHALL equal hold-buffer-full. A g_wr_en asserted while stalled SHALL be discarded.
REQ-014 hist_rd_en and g_hist_wea SHALL never both be 1 in the same cycle.
REQ-015 Reads SHALL be starvation-free: while remain != 0 and the FIFO has room, at least one read issues in every 2 consecutive cycles.
REQ-016 With g_hist_wea=0, g_hist_addra and g_hist_dia SHALL be 0.

Reset
REQ-017 lnk_reset high at a clock edge SHALL force state IDLE, addr=0, remain=0, FIFO empty, reads in flight cleared, hold buffer empty.
REQ-018 While in reset, every output SHALL be 0.
REQ-019 Reset mid-dump SHALL abandon the dump without a dump_done pulse. A read in flight SHALL NOT be captured.
REQ-020 On the first cycle after reset is released, dump_start SHALL be accepted.

Verification
REQ-021 Preload addr k with data k+0x100; dump_base=0, count=4, dump_ready=1 -> words 0x100..0x103 at addrs 0..3 on 4 consecutive cycles; dump_done 1 cycle after the last word; busy falls with done.
REQ-022 dump_base=510, count=4 -> dump_addr sequence 510, 511, 0, 1.
REQ-023 dump_ready=0 for 10 cycles mid-dump -> at most 2 reads outstanding; dump_data held stable; no word lost or duplicated after ready returns.
REQ-024 g_wr_en every cycle (obeying g_wr_stall) during a 16-word dump -> reads never coincide with writes; reads at least every other cycle; every non-stalled write appears on port A exactly once, in order.
REQ-025 count=0 -> dump_done 1 cycle after start; no hist_rd_en; busy stays 0.
REQ-026 lnk_reset asserted 3 words into a count=8 dump -> all outputs 0; no dump_done; a new start after release dumps correctly from its own dump_base.
